// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the uart_io_buffer peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // RX_BREAK holds off a new frame after a bad stop bit until the line returns high
    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_t;

    localparam int   ERR_TX_OVERRUN  = 0;
    localparam int   ERR_RX_UNDERRUN = 1;
    localparam int   ERR_RX_OVERRUN  = 2;
    localparam int   ERR_FRAME       = 3;
    localparam int   ERR_WIDTH       = 4;

    localparam logic UART_IDLE_LVL   = 1'b1;
    localparam int   FRAME_BITS      = 10;

endpackage
`default_nettype wire

// File: rtl/uart_io_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_io_buffer_if
// Description : CPU strobes, status lines and serial pins of the UART buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_io_buffer_if;

    logic       _uart_in;
    logic       _uart_out;
    logic [7:0] data_in;
    logic       _flag_do;
    logic       _flag_di;
    logic       txd;
    logic       rxd;
    logic       clr_err;
    logic [3:0] err;

    modport master (
        output _uart_in, _uart_out, data_in, rxd, clr_err,
        input  _flag_do, _flag_di, txd, err
    );

    modport slave (
        input  _uart_in, _uart_out, data_in, rxd, clr_err,
        output _flag_do, _flag_di, txd, err
    );

endinterface
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync_fifo
// Description : Single-clock FIFO, show-ahead read, push accepted when full
//               only if a pop coincides.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int           AW       = $clog2(DEPTH);
    localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic             push_ok, pop_ok;

    always_comb begin
        pop_ok   = pop && (count_q != '0);
        push_ok  = push && ((count_q != FULL_CNT) || pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/uart_io_buffer.sv
`default_nettype none
// ============================================================================
// Module      : uart_io_buffer
// Description : CPU-side 8N1 UART with TX/RX FIFOs, JMPDO/JMPDI status flags
//               and sticky error bits. Define UART_LOOPBACK_EN to feed the
//               deserialiser from the serialiser output instead of rxd.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_io_buffer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic             clk,
    input  logic             reset,
    uart_io_buffer_if.slave  bus,
    output wire [7:0]        data_out
);
    import uart_pkg::*;

    localparam int              BW        = $clog2(CLKS_PER_BIT);
    localparam int              CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]   BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]   FULL_CNT  = CW'(FIFO_DEPTH);

    logic [7:0]    tx_dout, rx_dout;
    logic [CW-1:0] tx_count, rx_count;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic          tx_push, tx_pop, rx_push, rx_pop;

    tx_state_t     tx_state_q;
    logic [BW-1:0] tx_baud_q;
    logic [2:0]    tx_bit_q;
    logic [7:0]    tx_shift_q;
    logic          txd_q;
    logic          tx_baud_end;

    rx_state_t     rx_state_q;
    logic [BW-1:0] rx_baud_q;
    logic [2:0]    rx_bit_q;
    logic [7:0]    rx_shift_q;
    logic          rx_meta_q, rx_sync_q, rx_in;
    logic          rx_baud_end, rx_frame_err;

    logic [ERR_WIDTH-1:0] err_q, err_d;
    logic                 flag_do_q, flag_do_d;
    logic                 flag_di_q, flag_di_d;

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop), .din(bus.data_in),
        .dout(tx_dout), .count(tx_count), .full(tx_full), .empty(tx_empty)
    );

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_push), .pop(rx_pop), .din(rx_shift_q),
        .dout(rx_dout), .count(rx_count), .full(rx_full), .empty(rx_empty)
    );

    assign tx_push     = ~bus._uart_in;
    assign rx_pop      = ~bus._uart_out;
    assign tx_baud_end = (tx_baud_q == BAUD_LAST);
    assign tx_pop      = !tx_empty &&
                         ((tx_state_q == TX_IDLE) || ((tx_state_q == TX_STOP) && tx_baud_end));

    // txd follows the state one cycle late, so a write into an idle empty FIFO
    // shows its start bit two edges after the write edge
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= UART_IDLE_LVL;
        end else begin
            case (tx_state_q)
                TX_START: txd_q <= ~UART_IDLE_LVL;
                TX_DATA:  txd_q <= tx_shift_q[0];
                default:  txd_q <= UART_IDLE_LVL;
            endcase
            if (tx_state_q != TX_IDLE) begin
                tx_baud_q <= tx_baud_end ? '0 : tx_baud_q + 1'b1;
            end
            case (tx_state_q)
                TX_IDLE: begin
                    if (tx_pop) begin
                        tx_shift_q <= tx_dout;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_baud_end) begin
                        tx_bit_q   <= '0;
                        tx_state_q <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_baud_end) begin
                        tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                        tx_bit_q   <= tx_bit_q + 1'b1;
                        if (tx_bit_q == 3'd7) begin
                            tx_state_q <= TX_STOP;
                        end
                    end
                end
                TX_STOP: begin
                    if (tx_baud_end) begin
                        if (tx_pop) begin
                            tx_shift_q <= tx_dout;
                            tx_state_q <= TX_START;
                        end else begin
                            tx_state_q <= TX_IDLE;
                        end
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= UART_IDLE_LVL;
            rx_sync_q <= UART_IDLE_LVL;
        end else begin
            rx_meta_q <= bus.rxd;
            rx_sync_q <= rx_meta_q;
        end
    end

`ifdef UART_LOOPBACK_EN
    assign rx_in = txd_q;
`else
    assign rx_in = rx_sync_q;
`endif

    assign rx_baud_end  = (rx_baud_q == BAUD_LAST);
    assign rx_push      = (rx_state_q == RX_STOP) && rx_baud_end && (rx_in == UART_IDLE_LVL);
    assign rx_frame_err = (rx_state_q == RX_STOP) && rx_baud_end && (rx_in != UART_IDLE_LVL);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q <= RX_IDLE;
            rx_baud_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    rx_baud_q <= '0;
                    if (rx_in != UART_IDLE_LVL) begin
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_baud_q == BAUD_HALF) begin
                        rx_baud_q  <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= (rx_in == UART_IDLE_LVL) ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_baud_q <= rx_baud_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    rx_baud_q <= rx_baud_end ? '0 : rx_baud_q + 1'b1;
                    if (rx_baud_end) begin
                        rx_shift_q <= {rx_in, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 1'b1;
                        if (rx_bit_q == 3'd7) begin
                            rx_state_q <= RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    rx_baud_q <= rx_baud_end ? '0 : rx_baud_q + 1'b1;
                    if (rx_baud_end) begin
                        rx_state_q <= rx_push ? RX_IDLE : RX_BREAK;
                    end
                end
                RX_BREAK: begin
                    rx_baud_q <= '0;
                    if (rx_in == UART_IDLE_LVL) begin
                        rx_state_q <= RX_IDLE;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // A fresh error in the same cycle as clr_err still sets its bit
    always_comb begin
        err_d = bus.clr_err ? '0 : err_q;
        if (tx_push && tx_full && !tx_pop) err_d[ERR_TX_OVERRUN]  = 1'b1;
        if (rx_pop && rx_empty)            err_d[ERR_RX_UNDERRUN] = 1'b1;
        if (rx_push && rx_full && !rx_pop) err_d[ERR_RX_OVERRUN]  = 1'b1;
        if (rx_frame_err)                  err_d[ERR_FRAME]       = 1'b1;
        flag_do_d = (tx_count == FULL_CNT);
        flag_di_d = (rx_count == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q     <= '0;
            flag_do_q <= 1'b0;
            flag_di_q <= 1'b1;
        end else begin
            err_q     <= err_d;
            flag_do_q <= flag_do_d;
            flag_di_q <= flag_di_d;
        end
    end

    assign bus.txd      = txd_q;
    assign bus._flag_do = flag_do_q;
    assign bus._flag_di = flag_di_q;
    assign bus.err      = err_q;
    assign data_out     = bus._uart_out ? 8'bz : (rx_empty ? 8'h00 : rx_dout);

endmodule
`default_nettype wire
